// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide data memory req/ack bus between the LSU and memory
interface load_store_unit_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  modport master (
    output m_req, m_we, m_addr, m_be, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    input  m_req, m_we, m_addr, m_be, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store bridge from core data port to req/ack memory
module load_store_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              fault,
  output logic              bus_err,
  load_store_unit_if.master mem
);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;

  logic          access, is_store, legal, start, acked, timeout;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [7:0]    byte_sh;
  logic [15:0]   half_sh;
  logic [31:0]   load_val;

  assign access   = mem_read | mem_write;
  assign is_store = mem_write;

  // Signed/unsigned sub-word loads exist only for loads; stores reject 100/101.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b100:  legal = !is_store;
      3'b001:  legal = !addr[0];
      3'b101:  legal = !is_store && !addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << addr[1:0];
          wdata_next = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << addr[1:0];
          wdata_next = {2{wdata[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sh = 8'(mem.m_rdata >> {lane_q, 3'b000});
    half_sh = 16'(mem.m_rdata >> {lane_q[1], 4'b0000});
    case (f3_q)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh};
      3'b100:  load_val = {24'h0, byte_sh};
      3'b001:  load_val = {{16{half_sh[15]}}, half_sh};
      3'b101:  load_val = {16'h0, half_sh};
      default: load_val = mem.m_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    acked      = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (access && legal) begin
          start      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem.m_ack) begin
          acked      = 1'b1;
          state_next = DONE;
        end else if (cnt == LAST) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so the core sees no stall/fault while the unit is held in reset.
  assign stall     = reset && ((state == REQ) || ((state == IDLE) && access && legal));
  assign fault     = reset && (state == IDLE) && access && !legal;
  assign mem.m_req = (state == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      mem.m_we    <= 1'b0;
      mem.m_addr  <= 32'h0;
      mem.m_be    <= 4'h0;
      mem.m_wdata <= 32'h0;
      rdata       <= 32'h0;
      bus_err     <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= timeout;
      if (start) begin
        cnt         <= '0;
        f3_q        <= funct3;
        lane_q      <= addr[1:0];
        mem.m_we    <= is_store;
        mem.m_addr  <= {addr[31:2], 2'b00};
        mem.m_be    <= be_next;
        mem.m_wdata <= wdata_next;
      end
      if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
      if (acked && !mem.m_we) begin
        rdata <= load_val;
      end else if (timeout) begin
        rdata <= 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench with a byte-arithmetic reference model
module tb_load_store_unit;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, fault, bus_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata = 32'h0;

  load_store_unit_if bus ();

  load_store_unit #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .fault(fault), .bus_err(bus_err), .mem(bus.master)
  );

  always #5 clk = ~clk;

  // k = REQ cycle carrying m_ack; 0 or >MAXW means the memory never answers.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                            input int k);
    logic        st;
    int          n, off, stall_cnt, j;
    logic        legal, acked;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    longint      v;
    st    = wr;
    n     = 1 << f3[1:0];
    off   = a % 4;
    legal = ((f3 inside {3'd0, 3'd1, 3'd2}) || (!st && (f3 inside {3'd4, 3'd5}))) && ((a % n) == 0);
    e_be  = st ? 4'(((1 << n) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    v = (longint'(mrd) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
    if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    e_ld  = v[31:0];
    acked = (k >= 1) && (k <= MAXW);

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus.m_ack = 1'b0; bus.m_rdata = $urandom;
    #4;
    checks++; if (stall !== legal) begin errors++; $display("FAIL %s idle_stall: got %b want %b", tag, stall, legal); end
    checks++; if (fault !== !legal) begin errors++; $display("FAIL %s idle_fault: got %b want %b", tag, fault, !legal); end
    if (!legal) begin
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #5;
        checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL %s fault_req: got %b want 0", tag, bus.m_req); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s fault_rdata: got %h want %h", tag, rdata, exp_rdata); end
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    stall_cnt = 1;
    j = 0;
    while (1) begin
      j++;
      @(posedge clk); #1;
      bus.m_ack   = (j == k);
      bus.m_rdata = (j == k) ? mrd : $urandom;
      #4;
      if (stall) stall_cnt++;
      checks++; if (bus.m_req !== 1'b1) begin errors++; $display("FAIL %s req_high c%0d: got %b want 1", tag, j, bus.m_req); end
      if (j == 1) begin
        checks++; if (bus.m_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s m_addr: got %h want %h", tag, bus.m_addr, {a[31:2], 2'b00}); end
        checks++; if (bus.m_be !== e_be) begin errors++; $display("FAIL %s m_be: got %b want %b", tag, bus.m_be, e_be); end
        checks++; if (bus.m_we !== st) begin errors++; $display("FAIL %s m_we: got %b want %b", tag, bus.m_we, st); end
        if (st) begin
          checks++; if (bus.m_wdata !== e_wd) begin errors++; $display("FAIL %s m_wdata: got %h want %h", tag, bus.m_wdata, e_wd); end
        end
      end
      if ((j == k) || (j >= MAXW)) break;
    end
    if (acked && !st) exp_rdata = e_ld;
    else if (!acked) exp_rdata = 32'h0;
    @(posedge clk); #1;
    bus.m_ack   = !acked;
    bus.m_rdata = $urandom;
    #4;
    checks++; if (stall_cnt !== (acked ? 1 + k : 1 + MAXW)) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cnt, acked ? 1 + k : 1 + MAXW); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s done_stall: got %b want 0", tag, stall); end
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL %s done_req: got %b want 0", tag, bus.m_req); end
    checks++; if (bus_err !== !acked) begin errors++; $display("FAIL %s done_bus_err: got %b want %b", tag, bus_err, !acked); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s done_rdata: got %h want %h", tag, rdata, exp_rdata); end
    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    #4;
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL %s idle_req: got %b want 0", tag, bus.m_req); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL %s idle_bus_err: got %b want 0", tag, bus_err); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s idle_rdata: got %h want %h", tag, rdata, exp_rdata); end
  endtask

  task automatic test_reset();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
    reset = 1'b0; mem_read = 1'b1; funct3 = 3'b011; addr = 32'h3;
    repeat (2) @(posedge clk);
    #5;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if ({bus.m_req, bus.m_we, bus.m_be, bus_err} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {bus.m_req, bus.m_we, bus.m_be, bus_err}); end
    checks++; if ({bus.m_addr, bus.m_wdata, rdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.m_addr, bus.m_wdata, rdata}); end
    mem_read = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_word_load();
    run_access("lw_0x64", 1'b1, 1'b0, 3'b010, 32'h64, 32'h0, 32'hDEADBEEF, 1);
  endtask

  task automatic test_byte_load();
    run_access("lb_0x67", 1'b1, 1'b0, 3'b000, 32'h67, 32'h0, 32'h80FF0000, 2);
    checks++; if (rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_value: got %h want ffffff80", rdata); end
    run_access("lbu_0x67", 1'b1, 1'b0, 3'b100, 32'h67, 32'h0, 32'h80FF0000, 1);
    checks++; if (rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_value: got %h want 00000080", rdata); end
  endtask

  task automatic test_half_store();
    run_access("sh_0x62", 1'b0, 1'b1, 3'b001, 32'h62, 32'h1234ABCD, 32'h0, 3);
  endtask

  task automatic test_fault();
    run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h65, 32'h0, 32'h0, 1);
    run_access("sw_f100", 1'b0, 1'b1, 3'b100, 32'h60, 32'h5, 32'h0, 1);
    run_access("ld_f011", 1'b1, 1'b0, 3'b011, 32'h60, 32'h0, 32'h0, 1);
    run_access("both_lhu", 1'b1, 1'b1, 3'b101, 32'h60, 32'h0, 32'h0, 1);
  endtask

  task automatic test_timeout();
    run_access("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 0);
    run_access("lw_last_ack", 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, MAXW);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h64; bus.m_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b want 0", bus.m_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b want 0", stall); end
    #2 mem_read = 1'b0;
    exp_rdata = 32'h0;
    #1 reset = 1'b1;
    run_access("lw_after_reset", 1'b1, 1'b0, 3'b010, 32'h64, 32'h0, 32'hDEADBEEF, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int op;
      op = $urandom_range(0, 2);
      run_access($sformatf("rand%0d", t), op != 1, op != 0, 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, $urandom_range(0, MAXW));
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
